// File: rtl/pool_mem_sched_2.sv
// Pool memory scheduler: runs num_frames layer/consumer handshakes per start and
// hands the shared pool memories to the layer (LAYER) or the next layer (READ).
// Ports:
//   clock, reset                  - sole clock, synchronous active-high reset
//   start, num_frames             - run request and frame count
//   layer_enable, layer_restart   - layer-2 enable and between-frame re-arm pulse
//   pool_done                     - layer-2 frame complete
//   prod_*                        - pool-writer memory requests
//   cons_req/grant/done, cons_*   - next-layer handshake and read requests
//   mem_*                         - shared pool-memory bus (combinational on state)
//   busy, frame_cnt, run_done     - run status
//   err_access                    - sticky producer access outside LAYER
module pool_mem_sched_2 #(
    parameter int unsigned POOL_ADDR_WIDTH = 10,
    parameter int unsigned FRAME_W         = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [FRAME_W-1:0]         num_frames,
    output logic                       layer_enable,
    output logic                       layer_restart,
    input  logic                       pool_done,
    input  logic [POOL_ADDR_WIDTH-1:0] prod_addr_a,
    input  logic [POOL_ADDR_WIDTH-1:0] prod_addr_b,
    input  logic                       prod_rden_a,
    input  logic                       prod_rden_b,
    input  logic                       prod_wren_a,
    input  logic                       prod_wren_b,
    input  logic                       cons_req,
    output logic                       cons_grant,
    input  logic                       cons_done,
    input  logic [POOL_ADDR_WIDTH-1:0] cons_addr_a,
    input  logic [POOL_ADDR_WIDTH-1:0] cons_addr_b,
    input  logic                       cons_rden_a,
    input  logic                       cons_rden_b,
    output logic [POOL_ADDR_WIDTH-1:0] mem_addr_a,
    output logic [POOL_ADDR_WIDTH-1:0] mem_addr_b,
    output logic                       mem_rden_a,
    output logic                       mem_rden_b,
    output logic                       mem_wren_a,
    output logic                       mem_wren_b,
    output logic                       busy,
    output logic [FRAME_W-1:0]         frame_cnt,
    output logic                       run_done,
    output logic                       err_access
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LAYER    = 3'd1,
        WAIT_REQ = 3'd2,
        READ     = 3'd3,
        NEXT     = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [FRAME_W-1:0]   r_num;
    logic [FRAME_W-1:0]   r_frame_cnt;
    logic [FRAME_W-1:0]   w_cnt_inc;
    logic                 w_last;
    logic                 w_start_acc;
    logic                 w_run_start;
    logic                 w_zero_run;
    logic                 w_prod_access;
    // High once LAYER has been occupied for a full cycle; blocks a stale pool_done.
    logic                 r_layer_armed;
    logic                 r_layer_enable;
    logic                 r_layer_restart;
    logic                 r_cons_grant;
    logic                 r_busy;
    logic                 r_run_done;
    logic                 r_err_access;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_inc   = r_frame_cnt + FRAME_W'(1);
        w_last      = (w_cnt_inc == r_num);
        w_start_acc = 1'b0;
        w_run_start = 1'b0;
        w_zero_run  = 1'b0;
        case (r_state)
            IDLE: begin
                w_start_acc = start;
                if (start) begin
                    if (num_frames != '0) begin
                        w_run_start = 1'b1;
                        w_state_nxt = LAYER;
                    end else begin
                        w_zero_run  = 1'b1;
                    end
                end
            end
            LAYER:    if (pool_done && r_layer_armed) w_state_nxt = WAIT_REQ;
            WAIT_REQ: if (cons_req)                   w_state_nxt = READ;
            READ:     if (cons_done)                  w_state_nxt = NEXT;
            NEXT:     w_state_nxt = w_last ? IDLE : LAYER;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Shared memory bus mux
    always_comb begin
        mem_addr_a = '0;
        mem_addr_b = '0;
        mem_rden_a = 1'b0;
        mem_rden_b = 1'b0;
        mem_wren_a = 1'b0;
        mem_wren_b = 1'b0;
        case (r_state)
            LAYER: begin
                mem_addr_a = prod_addr_a;
                mem_addr_b = prod_addr_b;
                mem_rden_a = prod_rden_a;
                mem_rden_b = prod_rden_b;
                mem_wren_a = prod_wren_a;
                mem_wren_b = prod_wren_b;
            end
            READ: begin
                mem_addr_a = cons_addr_a;
                mem_addr_b = cons_addr_b;
                mem_rden_a = cons_rden_a;
                mem_rden_b = cons_rden_b;
            end
            default: ;
        endcase
    end

    assign w_prod_access = prod_rden_a | prod_rden_b | prod_wren_a | prod_wren_b;

    // State and registered outputs; outputs follow the state being entered
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IDLE;
            r_num           <= '0;
            r_frame_cnt     <= '0;
            r_layer_armed   <= 1'b0;
            r_layer_enable  <= 1'b0;
            r_layer_restart <= 1'b0;
            r_cons_grant    <= 1'b0;
            r_busy          <= 1'b0;
            r_run_done      <= 1'b0;
            r_err_access    <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_layer_armed   <= (r_state == LAYER) && (w_state_nxt == LAYER);
            r_layer_enable  <= (w_state_nxt == LAYER);
            r_cons_grant    <= (w_state_nxt == READ);
            r_busy          <= (w_state_nxt != IDLE);
            r_layer_restart <= (r_state == NEXT) && !w_last;
            r_run_done      <= w_zero_run || ((r_state == NEXT) && w_last);
            if (w_run_start) begin
                r_num       <= num_frames;
                r_frame_cnt <= '0;
            end else if (r_state == NEXT) begin
                r_frame_cnt <= w_cnt_inc;
            end
            // Clear on accepted start, but a violation in the same cycle still sets
            r_err_access    <= (r_err_access && !w_start_acc) ||
                               (w_prod_access && (r_state != LAYER));
        end
    end

    assign layer_enable  = r_layer_enable;
    assign layer_restart = r_layer_restart;
    assign cons_grant    = r_cons_grant;
    assign busy          = r_busy;
    assign frame_cnt     = r_frame_cnt;
    assign run_done      = r_run_done;
    assign err_access    = r_err_access;

endmodule

// File: doc/pool_mem_sched_2.md
POOL_MEM_SCHED_2 -- requirements
Module: pool_mem_sched_2

Interface
REQ-001 Parameter POOL_ADDR_WIDTH, default 10, SHALL set the pool memory address width.
REQ-002 Parameter FRAME_W, default 8, SHALL set the width of the frame count and frame counter.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 The ports SHALL be:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle run request
- num_frames  in  FRAME_W  frames per run; latched on accepted start
- layer_enable  out  1  enable to the layer-2 control/datapath
- layer_restart  out  1  one-cycle pulse that re-arms the layer between frames
- pool_done  in  1  layer-2 frame-complete indication
- prod_addr_a, prod_addr_b  in  POOL_ADDR_WIDTH each  pool-writer addresses
- prod_rden_a, prod_rden_b, prod_wren_a, prod_wren_b  in  1 each  pool-writer strobes
- cons_req  in  1  next-layer read request
- cons_grant  out  1  next layer owns the pool memories
- cons_done  in  1  next layer finished reading
- cons_addr_a, cons_addr_b  in  POOL_ADDR_WIDTH each  reader addresses
- cons_rden_a, cons_rden_b  in  1 each  reader strobes
- mem_addr_a, mem_addr_b  out  POOL_ADDR_WIDTH each  shared pool-memory addresses (the *_use bus)
- mem_rden_a, mem_rden_b, mem_wren_a, mem_wren_b  out  1 each  shared pool-memory strobes
- busy  out  1  high whenever the state is not IDLE
- frame_cnt  out  FRAME_W  frames completed in the current run
- run_done  out  1  one-cycle pulse at the end of a run
- err_access  out  1  sticky illegal-producer-access flag

Function
REQ-005 The FSM SHALL have the states IDLE, LAYER, WAIT_REQ, READ and NEXT, held in a register.
REQ-006 IDLE: start with num_frames!=0 SHALL latch num_frames, clear frame_cnt, clear err_access and go to LAYER; start with num_frames==0 SHALL pulse run_done on the next cycle and stay in IDLE.
REQ-007 LAYER: layer_enable SHALL be 1; pool_done=1 SHALL go to WAIT_REQ.
REQ-008 WAIT_REQ: cons_req=1 SHALL go to READ.
REQ-009 READ: cons_grant SHALL be 1; cons_done=1 SHALL go to NEXT, and cons_done SHALL take priority over a simultaneous cons_req.
REQ-010 NEXT (one cycle): frame_cnt SHALL increment; if the incremented value equals the latched num_frames, go to IDLE and pulse run_done in that cycle; otherwise pulse layer_restart and go to LAYER.
REQ-011 layer_enable, cons_grant, busy, layer_restart and run_done SHALL be registered and change on the same edge as the state they belong to.
REQ-012 The mem_* mux SHALL be combinational on the registered state, with zero added latency:
- LAYER: mem_* = prod_*
- READ: mem_addr/mem_rden = cons_*, mem_wren_a = mem_wren_b = 0
- all other states: all mem_* = 0
REQ-013 err_access SHALL set when any prod_rden/prod_wren is 1 while the state is not LAYER, and SHALL hold until reset or an accepted start.
REQ-014 start SHALL be ignored outside IDLE; pool_done SHALL be ignored outside LAYER; cons_req and cons_done SHALL be ignored outside WAIT_REQ and READ respectively.
REQ-015 A pool_done held high across a layer_restart SHALL NOT complete the next frame; LAYER SHALL respond only to pool_done sampled at least one cycle after entering LAYER.
REQ-016 frame_cnt SHALL wrap modulo 2^FRAME_W; with num_frames = 2^FRAME_W - 1 the run SHALL end without wrap.

Reset
REQ-017 When reset=1 at a clock edge, the state SHALL become IDLE, all outputs SHALL become 0 (frame_cnt=0, err_access=0), and any latched num_frames SHALL be discarded, regardless of the current state.

Verification
REQ-018 num_frames=2, start; pool_done after 20 cycles; cons_req, then cons_done after 10 cycles; repeat -> frame_cnt steps 1,2; one layer_restart pulse; run_done pulses once; busy returns to 0.
REQ-019 In LAYER, prod_addr_a=0x155, prod_wren_a=1 -> mem_addr_a=0x155 and mem_wren_a=1 in the same cycle. In READ, cons_addr_b=0x2AA, cons_rden_b=1, prod_wren_b=1 -> mem_addr_b=0x2AA, mem_rden_b=1, mem_wren_b=0, and err_access=1.
REQ-020 start with num_frames=0 -> run_done pulses one cycle later; layer_enable stays 0.
REQ-021 Reset asserted in READ with cons_grant=1 -> next cycle: cons_grant=0, busy=0, all mem_* = 0; start is accepted afterwards.
REQ-022 pool_done held high through NEXT -> the new LAYER visit lasts at least 2 cycles before moving to WAIT_REQ. cons_req and cons_done high together in READ -> NEXT is entered.
